adder_8_bit_seq_ctrl: RTL and testbench
=======================================

Name: adder_8_bit_seq_ctrl

Overview:
Sequencer that performs multi-byte (NBYTES×8-bit) add/subtract by reusing one 8-bit ripple-carry adder slice, one byte per clock. Byte 0 (LSB) is processed first, and the carry is chained between bytes in a register. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. The 8-bit slice is internal to the block.

Parameters:
NBYTES, 4, number of byte lanes per operand (≥1); operand width W = 8*NBYTES.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  producer presents a request.
in_ready  output  1  block can accept a request.
op_a  input  W  operand A, sampled on accept.
op_b  input  W  operand B, sampled on accept.
carry_in  input  1  carry seed for add; ignored when sub=1.
sub  input  1  0: A+B+carry_in; 1: A−B (two's complement).
out_valid  output  1  result is valid.
out_ready  input  1  consumer takes the result.
result  output  W  sum or difference.
carry_out  output  1  carry out of bit W−1. For subtract: 1 means no borrow.
overflow  output  1  signed overflow = carry into bit W−1 XOR carry_out.
busy  output  1  high in RUN state.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. Assertion takes effect immediately; release is sampled on clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, carry_out=0, overflow=0. All internal byte index, carry and operand registers are also 0.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: capture op_a into A_reg.
  - Capture B_reg = sub ? ~op_b : op_b.
  - Set carry = sub ? 1 : carry_in, idx=0, result=0.
  - Go to RUN.
- RUN:
  - in_ready=0, busy=1.
  - Each edge: slice computes {c, s} = A_reg[idx] + B_reg[idx] + carry over one byte.
  - Write s to result[8*idx +: 8], set carry=c, idx=idx+1.
  - On the edge processing idx=NBYTES−1: latch carry_out=c and overflow = (carry into bit 7 of that byte) XOR c. Go to DONE.
  - in_valid is ignored in RUN.
- DONE:
  - out_valid=1; result, carry_out and overflow are held stable.
  - On an edge with out_ready=1: go to IDLE and clear out_valid.
  - No request is accepted in the same cycle as a DONE-state handshake. in_ready rises the cycle after.
- Latency: the accept edge is E0; out_valid is high after edge E0+NBYTES. Throughput is one operation per NBYTES+2 cycles with out_ready held high.
- Widths: all arithmetic is modulo 2^W. The idx counter is ceil(log2(NBYTES)) bits, minimum 1 bit. Its wrap is never reached because the state changes at NBYTES−1.
- Boundary cases:
  - NBYTES=1: RUN lasts one cycle.
  - out_ready held low: DONE persists indefinitely and outputs do not change.
  - out_ready high before DONE: has no effect.
  - Reset asserted mid-RUN or in DONE: the operation is discarded, all outputs go to reset values, and no partial result is ever flagged valid.
  - Operand inputs changing after accept: no effect on the result.

Test Plan:
(All scenarios use NBYTES=4.)
1. Add: a=0x000000FF, b=0x00000001, carry_in=0, sub=0 → result=0x00000100, carry_out=0, overflow=0. out_valid rises exactly 4 cycles after the accept edge; busy is high for those 4 cycles.
2. Full carry ripple: a=0xFFFFFFFF, b=0x00000001 → result=0x00000000, carry_out=1, overflow=0. Then a=0x7FFFFFFF, b=0, carry_in=1 → result=0x80000000, carry_out=0, overflow=1.
3. Subtract:
   - a=5, b=7, sub=1, carry_in=1 → result=0xFFFFFFFE, carry_out=0, overflow=0. This also shows carry_in is ignored.
   - a=0x80000000, b=1, sub=1 → result=0x7FFFFFFF, carry_out=1, overflow=1.
4. Backpressure: hold out_ready=0 for 10 cycles in DONE, toggling in_valid and the operands → result, carry_out and overflow are unchanged and in_ready=0. Raise out_ready → out_valid falls after 1 edge, and in_ready=1 the next cycle.
5. Reset mid-operation: assert rst_n=0 after 2 RUN cycles → immediately out_valid=0, result=0, in_ready=1. After release, scenario 1 reproduces exact results and latency.
6. Back-to-back: keep in_valid=1 and out_ready=1 continuously with 3 operations (scenarios 1, 2 and 3 values) → accepts are spaced exactly 6 cycles apart and each result matches.

Source files
------------

// File: rtl/adder_8_bit_seq_ctrl.sv
// adder_8_bit_seq_ctrl
//
// Multi-byte add/subtract sequencer. One 8-bit ripple-carry slice is reused
// once per clock, least significant byte first. The carry between bytes is
// kept in a register. Operands are captured when a request is accepted, so
// the producer may change them at any time afterwards.
//
// Parameters:
//   NBYTES    - number of byte lanes per operand (>= 1), W = 8*NBYTES
//
// Ports:
//   clk       - system clock, rising edge
//   rst_n     - asynchronous active-low reset
//   in_valid  - producer presents a request
//   in_ready  - block can accept a request (IDLE)
//   op_a      - operand A, sampled on accept
//   op_b      - operand B, sampled on accept
//   carry_in  - carry seed for add, ignored when sub=1
//   sub       - 0: A+B+carry_in, 1: A-B
//   out_valid - result is valid (DONE)
//   out_ready - consumer takes the result
//   result    - sum or difference, modulo 2^W
//   carry_out - carry out of bit W-1 (for subtract, 1 means no borrow)
//   overflow  - signed overflow of the whole W-bit operation
//   busy      - high while bytes are being processed (RUN)

module adder_8_bit_seq_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   op_a,
  input  logic [8*NBYTES-1:0]   op_b,
  input  logic                  carry_in,
  input  logic                  sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   result,
  output logic                  carry_out,
  output logic                  overflow,
  output logic                  busy
);

  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  // Operands and result are kept as byte arrays so the current byte lane
  // can be picked directly with the byte index.
  logic [NBYTES-1:0][7:0] a_reg;
  logic [NBYTES-1:0][7:0] b_reg;
  logic [NBYTES-1:0][7:0] result_q;
  logic                   carry_reg;
  logic [IDXW-1:0]        idx;
  logic                   carry_out_q;
  logic                   overflow_q;

  logic [7:0] slice_a;
  logic [7:0] slice_b;
  logic [7:0] slice_sum;
  logic [8:0] chain;

  // The shared 8-bit ripple-carry slice. chain[i] is the carry into bit i
  // of the current byte, so chain[7] is the carry into the byte's sign bit
  // and chain[8] is the carry out of the byte.
  always_comb begin
    slice_a   = a_reg[idx];
    slice_b   = b_reg[idx];
    slice_sum = '0;
    chain     = '0;
    chain[0]  = carry_reg;
    for (int i = 0; i < 8; i++) begin
      slice_sum[i] = slice_a[i] ^ slice_b[i] ^ chain[i];
      chain[i+1]   = (slice_a[i] & slice_b[i]) | (chain[i] & (slice_a[i] ^ slice_b[i]));
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs. DONE returns to IDLE rather than
  // accepting directly, so a new request is never taken on the same edge
  // as the result handshake.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (idx == LAST_IDX) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath. Subtraction is done as A + ~B + 1, so the operand is
  // inverted at capture time and the carry seed is forced to 1. The
  // result and flags are only written in IDLE (on accept) and RUN, which
  // keeps them stable for the whole DONE state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg       <= '0;
      b_reg       <= '0;
      result_q    <= '0;
      carry_reg   <= 1'b0;
      idx         <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_reg       <= op_a;
            b_reg       <= sub ? ~op_b : op_b;
            carry_reg   <= sub ? 1'b1 : carry_in;
            idx         <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
          end
        end
        RUN: begin
          result_q[idx] <= slice_sum;
          carry_reg     <= chain[8];
          idx           <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            carry_out_q <= chain[8];
            overflow_q  <= chain[7] ^ chain[8];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_adder_8_bit_seq_ctrl.sv
// Testbench for adder_8_bit_seq_ctrl (NBYTES = 4).
//
// A behavioural model tracks each accepted operation with plain W-bit and
// signed arithmetic plus a cycle age, and a compare process checks the DUT
// against it on every falling edge. Directed scenarios add literal
// expectations for results, latency and handshake timing.

module tb_adder_8_bit_seq_ctrl;

  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         carry_in;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  adder_8_bit_seq_ctrl #(.NBYTES(NBYTES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .carry_in  (carry_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .busy      (busy)
  );

  // Free-running clock and a cycle counter used to measure accept spacing.
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Single comparison point: counts every check and reports any difference.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference arithmetic: add is A+B+cin, subtract is A-B. Carry for the
  // subtract is "no borrow", and overflow is the signed result falling
  // outside the W-bit two's complement range.
  function automatic logic [W+1:0] modelOp(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic do_sub);
    logic [W:0] full;
    logic       c;
    logic       ov;
    longint     sa;
    longint     sb;
    longint     s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (do_sub) begin
      full = {1'b0, a - b};
      c    = (a >= b);
      s    = sa - sb;
    end else begin
      full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      c    = full[W];
      s    = sa + sb + longint'(cin);
    end
    ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    return {ov, c, full[W-1:0]};
  endfunction

  // Model state: whether an operation is outstanding, how many edges have
  // passed since its accept, and whether nothing has been accepted since reset.
  logic         m_pend  = 1'b0;
  int           m_age   = 0;
  logic         m_clean = 1'b1;
  logic [W-1:0] m_res   = '0;
  logic         m_c     = 1'b0;
  logic         m_o     = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend  <= 1'b0;
      m_age   <= 0;
      m_clean <= 1'b1;
    end else if (m_pend) begin
      if (m_age < NBYTES) begin
        m_age <= m_age + 1;
      end else if (out_ready) begin
        m_pend <= 1'b0;
      end
    end else if (in_valid) begin
      m_pend  <= 1'b1;
      m_age   <= 0;
      m_clean <= 1'b0;
      {m_o, m_c, m_res} <= modelOp(op_a, op_b, carry_in, sub);
    end
  end

  // Every-cycle comparison against the model on the falling edge.
  always @(negedge clk) begin
    if (!m_pend) begin
      checkOutput("idle in_ready", in_ready, 1);
      checkOutput("idle out_valid", out_valid, 0);
      checkOutput("idle busy", busy, 0);
      if (m_clean) begin
        checkOutput("clean result", result, 0);
        checkOutput("clean carry_out", carry_out, 0);
        checkOutput("clean overflow", overflow, 0);
      end
    end else if (m_age < NBYTES) begin
      checkOutput("run busy", busy, 1);
      checkOutput("run out_valid", out_valid, 0);
      checkOutput("run in_ready", in_ready, 0);
    end else begin
      checkOutput("done out_valid", out_valid, 1);
      checkOutput("done busy", busy, 0);
      checkOutput("done in_ready", in_ready, 0);
      checkOutput("done result", result, m_res);
      checkOutput("done carry_out", carry_out, m_c);
      checkOutput("done overflow", overflow, m_o);
    end
  end

  // Runs one operation with literal expectations: latency, busy length,
  // result flags, optional out_ready backpressure, and release timing.
  task automatic applyStimulus(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cin, input logic do_sub, input logic [W-1:0] exp_res,
                               input logic exp_c, input logic exp_o, input int hold);
    int n;
    int lat;
    int bcnt;
    @(negedge clk);
    op_a      = a;
    op_b      = b;
    carry_in  = cin;
    sub       = do_sub;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checkOutput({name, " accept timeout"}, 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op_a     = ~a;
    op_b     = ~b ^ 32'h5A5A_A5A5;
    carry_in = ~cin;
    sub      = ~do_sub;
    lat  = 0;
    bcnt = 0;
    while (out_valid !== 1'b1 && lat < 50) begin
      if (busy === 1'b1) bcnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput({name, " latency"}, lat, NBYTES);
    checkOutput({name, " busy cycles"}, bcnt, NBYTES);
    checkOutput({name, " result"}, result, exp_res);
    checkOutput({name, " carry_out"}, carry_out, exp_c);
    checkOutput({name, " overflow"}, overflow, exp_o);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      op_a     = $urandom;
      op_b     = $urandom;
      sub      = ~sub;
      @(posedge clk);
      #1;
      checkOutput({name, " hold result"}, result, exp_res);
      checkOutput({name, " hold carry_out"}, carry_out, exp_c);
      checkOutput({name, " hold overflow"}, overflow, exp_o);
      checkOutput({name, " hold in_ready"}, in_ready, 0);
      checkOutput({name, " hold out_valid"}, out_valid, 1);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput({name, " release out_valid"}, out_valid, 0);
    checkOutput({name, " release in_ready"}, in_ready, 1);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // Directed scenarios.
  initial begin
    int n;
    int acc[3];
    logic [W-1:0] va[3];
    logic [W-1:0] vb[3];
    logic         vc[3];
    logic         vs[3];

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    carry_in  = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset in_ready", in_ready, 1);
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset result", result, 0);
    checkOutput("reset carry_out", carry_out, 0);
    checkOutput("reset overflow", overflow, 0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus("add", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 0);
    applyStimulus("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 0);
    applyStimulus("add ovf", 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 0);
    applyStimulus("sub neg", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 0);
    applyStimulus("sub ovf hold", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 10);

    // Reset two RUN edges into an operation, when byte 1 already holds a
    // nonzero partial sum.
    @(negedge clk);
    op_a     = 32'h0000_00FF;
    op_b     = 32'h0000_0001;
    carry_in = 1'b0;
    sub      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset out_valid", out_valid, 0);
    checkOutput("midreset result", result, 0);
    checkOutput("midreset in_ready", in_ready, 1);
    checkOutput("midreset busy", busy, 0);
    checkOutput("midreset carry_out", carry_out, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("add after reset", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 0);

    // Back-to-back with in_valid and out_ready held high; results are
    // checked by the model, spacing here.
    va[0] = 32'h0000_00FF; vb[0] = 32'h0000_0001; vc[0] = 1'b0; vs[0] = 1'b0;
    va[1] = 32'hFFFF_FFFF; vb[1] = 32'h0000_0001; vc[1] = 1'b0; vs[1] = 1'b0;
    va[2] = 32'h0000_0005; vb[2] = 32'h0000_0007; vc[2] = 1'b1; vs[2] = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    op_a      = va[0];
    op_b      = vb[0];
    carry_in  = vc[0];
    sub       = vs[0];
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (in_ready !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) checkOutput("b2b accept timeout", 0, 1);
      acc[k] = cyc;
      @(posedge clk);
      #1;
      if (k < 2) begin
        op_a     = va[k+1];
        op_b     = vb[k+1];
        carry_in = vc[k+1];
        sub      = vs[k+1];
      end else begin
        in_valid = 1'b0;
      end
    end
    repeat (10) @(negedge clk);
    checkOutput("b2b spacing 0-1", acc[1] - acc[0], NBYTES + 2);
    checkOutput("b2b spacing 1-2", acc[2] - acc[1], NBYTES + 2);
    out_ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guard against a stuck handshake.
  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
